vga_sync_decoder: RTL and testbench

//  Receive end of the VGA timing interface: takes hsync/vsync/hblnk/vblnk from vga_timing
//  (or any source using the vga_pkg timing) and reconstructs hcount/vcount from them.

---
 rtl/vga_sync_decoder.sv | 162 ++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing monitor: rebuilds hcount/vcount from hsync/vsync/hblnk/vblnk,
// locks onto the stream, pulses err on any timing deviation and keeps a saturating error count.
module vga_sync_decoder #(
  parameter int unsigned H_TOTAL   = 1056,
  parameter int unsigned H_BLNK_ST = 800,
  parameter int unsigned H_SYNC_ST = 840,
  parameter int unsigned H_SYNC_SP = 968,
  parameter int unsigned V_TOTAL   = 628,
  parameter int unsigned V_BLNK_ST = 600,
  parameter int unsigned V_SYNC_ST = 601,
  parameter int unsigned V_SYNC_SP = 605
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic        hblnk_i,
  input  logic        vblnk_i,
  output logic [10:0] hcount_o,
  output logic [10:0] vcount_o,
  output logic        locked_o,
  output logic        frame_start_o,
  output logic        err_o,
  output logic [7:0]  err_cnt_o
);

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_BLNK   = 11'(H_BLNK_ST);
  localparam logic [10:0] H_SYNC_A = 11'(H_SYNC_ST);
  localparam logic [10:0] H_SYNC_B = 11'(H_SYNC_SP);
  localparam logic [10:0] H_PRE    = 11'(H_SYNC_ST - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_BLNK   = 11'(V_BLNK_ST);
  localparam logic [10:0] V_SYNC_A = 11'(V_SYNC_ST);
  localparam logic [10:0] V_SYNC_B = 11'(V_SYNC_SP);

  typedef enum logic [1:0] {SEARCH, H_TRACK, V_SEARCH, LOCKED} state_t;

  state_t      state_q;
  logic        hsync_q, vsync_q;
  logic [10:0] hcount_q, vcount_q;
  logic [1:0]  good_lines_q;
  logic        locked_q, frame_start_q, err_q;
  logic [7:0]  err_cnt_q;

  logic        h_rise, v_rise;
  logic [10:0] hcount_d, vcount_d;
  logic        h_mis, v_mis;

  function automatic logic in_win(input logic [10:0] x, input logic [10:0] lo,
                                  input logic [10:0] hi);
    return (x >= lo) && (x < hi);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  assign h_rise = hsync_i & ~hsync_q;
  assign v_rise = vsync_i & ~vsync_q;

  // Free-running successor of the counters; inputs are judged against its decode.
  always_comb begin
    hcount_d = (hcount_q == H_LAST) ? 11'd0 : hcount_q + 11'd1;
    vcount_d = (hcount_q != H_LAST) ? vcount_q :
               (vcount_q == V_LAST) ? 11'd0 : vcount_q + 11'd1;
    h_mis    = (hsync_i != in_win(hcount_d, H_SYNC_A, H_SYNC_B)) |
               (hblnk_i != (hcount_d >= H_BLNK));
    v_mis    = (vsync_i != in_win(vcount_d, V_SYNC_A, V_SYNC_B)) |
               (vblnk_i != (vcount_d >= V_BLNK));
  end

  // Lock FSM with counters and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= SEARCH;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      hcount_q      <= 11'd0;
      vcount_q      <= 11'd0;
      good_lines_q  <= 2'd0;
      locked_q      <= 1'b0;
      frame_start_q <= 1'b0;
      err_q         <= 1'b0;
      err_cnt_q     <= 8'd0;
    end else begin
      hsync_q       <= hsync_i;
      vsync_q       <= vsync_i;
      err_q         <= 1'b0;
      frame_start_q <= 1'b0;
      case (state_q)
        SEARCH: begin
          locked_q <= 1'b0;
          vcount_q <= 11'd0;
          if (h_rise) begin
            state_q      <= H_TRACK;
            hcount_q     <= H_SYNC_A;
            good_lines_q <= 2'd0;
          end
        end
        H_TRACK: begin
          if (h_rise) begin
            hcount_q <= H_SYNC_A;
            // A good line ends exactly one pixel before the sync pixel we reload.
            if (hcount_q == H_PRE) begin
              if (good_lines_q == 2'd1) begin
                good_lines_q <= 2'd2;
                state_q      <= V_SEARCH;
              end else begin
                good_lines_q <= good_lines_q + 2'd1;
              end
            end else begin
              good_lines_q <= 2'd0;
              err_q        <= 1'b1;
              err_cnt_q    <= sat_inc(err_cnt_q);
            end
          end else begin
            hcount_q <= hcount_d;
          end
        end
        V_SEARCH: begin
          if (h_mis) begin
            err_q     <= 1'b1;
            err_cnt_q <= sat_inc(err_cnt_q);
            state_q   <= SEARCH;
          end else begin
            hcount_q <= hcount_d;
            if (v_rise) begin
              vcount_q <= V_SYNC_A;
              locked_q <= 1'b1;
              state_q  <= LOCKED;
            end
          end
        end
        LOCKED: begin
          if (h_mis | v_mis) begin
            err_q     <= 1'b1;
            err_cnt_q <= sat_inc(err_cnt_q);
            locked_q  <= 1'b0;
            state_q   <= SEARCH;
          end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            frame_start_q <= (hcount_d == 11'd0) && (vcount_d == 11'd0);
          end
        end
        default: begin
          state_q  <= SEARCH;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign hcount_o      = hcount_q;
  assign vcount_o      = vcount_q;
  assign locked_o      = locked_q;
  assign frame_start_o = frame_start_q;
  assign err_o         = err_q;
  assign err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder: a scaled-down timing source with injectable faults, and
// expectations derived from the stream (sync rises, frame position) rather than DUT state.
module tb_vga_sync_decoder;

  localparam int HT = 16, HB = 10, HS = 11, HP = 14;
  localparam int VT = 7,  VB = 4,  VS = 5,  VP = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hsync = 1'b0, vsync = 1'b0, hblnk = 1'b0, vblnk = 1'b0;
  logic [10:0] hcount, vcount;
  logic        locked, frame_start, err;
  logic [7:0]  err_cnt;

  vga_sync_decoder #(
    .H_TOTAL(HT), .H_BLNK_ST(HB), .H_SYNC_ST(HS), .H_SYNC_SP(HP),
    .V_TOTAL(VT), .V_BLNK_ST(VB), .V_SYNC_ST(VS), .V_SYNC_SP(VP)
  ) dut (
    .clk(clk), .rst(rst),
    .hsync_i(hsync), .vsync_i(vsync), .hblnk_i(hblnk), .vblnk_i(vblnk),
    .hcount_o(hcount), .vcount_o(vcount), .locked_o(locked),
    .frame_start_o(frame_start), .err_o(err), .err_cnt_o(err_cnt)
  );

  always #5 clk = ~clk;

  int   checks = 0, failures = 0;
  int   src_h = 0, src_v = 0, skip_h = -1;
  logic f_hs_low = 1'b0, f_vb_inv = 1'b0, rst_drv = 1'b1;
  logic prev_hs = 1'b0, prev_vs = 1'b0;

  // Present the current source position, clock it in, settle.
  task automatic step();
    @(negedge clk);
    rst   = rst_drv;
    hsync = (src_h >= HS && src_h < HP) && !f_hs_low;
    hblnk = (src_h >= HB);
    vsync = (src_v >= VS && src_v < VP);
    vblnk = (src_v >= VB) ^ f_vb_inv;
    @(posedge clk);
    #1;
  endtask

  task automatic advance();
    prev_hs = rst ? 1'b0 : hsync;
    prev_vs = rst ? 1'b0 : vsync;
    if (src_h == skip_h) begin
      src_h  = src_h + 2;
      skip_h = -1;
    end else begin
      src_h = src_h + 1;
    end
    if (src_h >= HT) begin
      src_h = src_h - HT;
      src_v = (src_v + 1) % VT;
    end
  endtask

  task automatic hold_reset(input int h0, input int v0);
    rst_drv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      advance();
    end
    src_h   = h0;
    src_v   = v0;
    rst_drv = 1'b0;
  endtask

  // Lock is expected at the first vsync rise after the third hsync rise following
  // SEARCH; a bad-period rise (index err_at) pulses err and restarts the count there.
  task automatic wait_lock(input int err_at, input string tag);
    int   rises, needed, n;
    logic hr, vr, exp_lock, exp_err, done;
    rises = 0; needed = 3; n = 0; done = 1'b0;
    while (!done && n < 2000) begin
      step();
      hr = hsync & ~prev_hs;
      vr = vsync & ~prev_vs;
      exp_err  = 1'b0;
      exp_lock = (rises >= needed) && vr;
      if (hr) begin
        rises++;
        if (rises == err_at) begin
          exp_err = 1'b1;
          needed  = rises + 2;
        end
      end
      checks++;
      if (locked !== exp_lock || err !== exp_err) begin
        failures++;
        $display("FAIL %s cycle %0d: locked=%b err=%b, expected locked=%b err=%b",
                 tag, n, locked, err, exp_lock, exp_err);
      end
      if (exp_lock) begin
        checks++;
        if (hcount !== 11'(src_h) || vcount !== 11'(src_v)) begin
          failures++;
          $display("FAIL %s lock position: h=%0d v=%0d, expected h=%0d v=%0d",
                   tag, hcount, vcount, src_h, src_v);
        end
        done = 1'b1;
      end
      advance();
      n++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s: locked=%b after %0d cycles, expected lock", tag, locked, n);
    end
  endtask

  // Clean locked stream: counters equal the source position, frame_start only at (0,0).
  task automatic track_locked(input int ncyc, input string tag,
                              output int fs_n, output int fs_gap);
    int   last;
    logic exp_fs;
    fs_n = 0; fs_gap = -1; last = -1;
    for (int n = 0; n < ncyc; n++) begin
      step();
      exp_fs = (src_h == 0) && (src_v == 0);
      checks++;
      if (locked !== 1'b1 || err !== 1'b0 || frame_start !== exp_fs ||
          hcount !== 11'(src_h) || vcount !== 11'(src_v)) begin
        failures++;
        $display("FAIL %s cycle %0d: lk=%b err=%b fs=%b h=%0d v=%0d, expected lk=1 err=0 fs=%b h=%0d v=%0d",
                 tag, n, locked, err, frame_start, hcount, vcount, exp_fs, src_h, src_v);
      end
      if (frame_start === 1'b1) begin
        if (last >= 0) fs_gap = n - last;
        last = n;
        fs_n++;
      end
      advance();
    end
  endtask

  task automatic check_cnt(input string tag, input int exp);
    checks++;
    if (err_cnt !== 8'(exp)) begin
      failures++;
      $display("FAIL %s: err_cnt=%0d, expected %0d", tag, err_cnt, exp);
    end
  endtask

  task automatic test_reset();
    hold_reset(0, 0);
    checks++;
    if (hcount !== 11'd0 || vcount !== 11'd0 || locked !== 1'b0 ||
        frame_start !== 1'b0 || err !== 1'b0 || err_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset: h=%0d v=%0d lk=%b fs=%b err=%b cnt=%0d, expected all 0",
               hcount, vcount, locked, frame_start, err, err_cnt);
    end
  endtask

  task automatic test_lock();
    int fs_n, fs_gap;
    hold_reset($urandom_range(HS - 1, 0), $urandom_range(VT - 1, 0));
    wait_lock(0, "lock");
    track_locked(3 * HT, "lock_track", fs_n, fs_gap);
  endtask

  task automatic test_frame_start();
    int fs_n, fs_gap;
    track_locked(2 * HT * VT, "frames", fs_n, fs_gap);
    checks++;
    if (fs_n != 2 || fs_gap != HT * VT) begin
      failures++;
      $display("FAIL frame_start: pulses=%0d gap=%0d, expected 2 and %0d", fs_n, fs_gap, HT * VT);
    end
    check_cnt("frames_cnt", 0);
  endtask

  task automatic test_hsync_drop();
    int   line, d, fs_n, fs_gap;
    logic exp_err, exp_lock;
    line = $urandom_range(VT - 1, VS - 2);
    d = (line * HT - (src_v * HT + src_h) + HT * VT) % (HT * VT);
    track_locked(d, "drop_pre", fs_n, fs_gap);
    f_hs_low = 1'b1;
    for (int n = 0; n < HT; n++) begin
      step();
      exp_err  = (src_h == HS);
      exp_lock = (src_h < HS);
      checks++;
      if (err !== exp_err || locked !== exp_lock || err_cnt !== ((src_h >= HS) ? 8'd1 : 8'd0)) begin
        failures++;
        $display("FAIL hsync_drop h=%0d: err=%b lk=%b cnt=%0d, expected err=%b lk=%b",
                 src_h, err, locked, err_cnt, exp_err, exp_lock);
      end
      advance();
    end
    f_hs_low = 1'b0;
    wait_lock(0, "drop_relock");
    check_cnt("drop_cnt", 1);
  endtask

  task automatic test_short_line();
    int fs_n, fs_gap;
    hold_reset(HS - 1, $urandom_range(VT - 1, 0));
    skip_h = 3;
    wait_lock(2, "short_line");
    check_cnt("short_cnt", 1);
    track_locked(HT, "short_track", fs_n, fs_gap);
  endtask

  task automatic test_saturation();
    int exp;
    hold_reset($urandom_range(HS - 1, 0), $urandom_range(VT - 1, 0));
    wait_lock(0, "sat_lock");
    for (int i = 0; i < 300; i++) begin
      f_vb_inv = 1'b1;
      step();
      f_vb_inv = 1'b0;
      exp = (i + 1 > 255) ? 255 : i + 1;
      checks++;
      if (err !== 1'b1 || locked !== 1'b0 || err_cnt !== 8'(exp)) begin
        failures++;
        $display("FAIL glitch %0d: err=%b lk=%b cnt=%0d, expected err=1 lk=0 cnt=%0d",
                 i, err, locked, err_cnt, exp);
      end
      advance();
      wait_lock(0, "sat_relock");
    end
  endtask

  task automatic test_async_reset();
    int fs_n, fs_gap;
    track_locked($urandom_range(HT * VT, 1), "pre_rst", fs_n, fs_gap);
    #1;
    rst     = 1'b1;
    rst_drv = 1'b1;
    #1;
    checks++;
    if (hcount !== 11'd0 || vcount !== 11'd0 || locked !== 1'b0 ||
        frame_start !== 1'b0 || err !== 1'b0 || err_cnt !== 8'd0) begin
      failures++;
      $display("FAIL async_rst: h=%0d v=%0d lk=%b fs=%b err=%b cnt=%0d, expected all 0",
               hcount, vcount, locked, frame_start, err, err_cnt);
    end
    do begin
      step();
      advance();
    end while (src_h != 0);
    prev_hs = 1'b0;
    prev_vs = 1'b0;
    rst_drv = 1'b0;
    wait_lock(0, "rst_relock");
    check_cnt("rst_cnt", 0);
  endtask

  initial begin
    test_reset();
    test_lock();
    test_frame_start();
    test_hsync_drop();
    test_short_line();
    test_saturation();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
